// File: rtl/ifu_fetch_if.sv
// Instruction-memory req/ack port between the fetch unit (master) and imem (slave).
// imem_addr is stable while imem_req is high; imem_rdata is valid with imem_ack.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifu_fetch.sv
// MIPS fetch unit: owns the PC, one fetch/cycle at zero-wait, stall parks an acked word in a hold buffer.
// IF/ID updates on the edge after ack; optional AdEL trap on bad fetch addresses under IFU_ADEL_EXC_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  ifu_fetch_if.master  imem,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
`ifdef IFU_ADEL_EXC_EN
  output logic [4:0]   id_exc,
`endif
  output logic [31:0]  id_pc8
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_e;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        addr_bad;
  logic        fetch_done;
  logic [31:0] fetch_instr;

`ifdef IFU_ADEL_EXC_EN
  logic [4:0]  buf_exc_q, buf_exc_d;
  logic [4:0]  id_exc_q, id_exc_d;
  // Misaligned or outside the instruction window: never reaches imem, completes as AdEL.
  assign addr_bad = (pc_q[1:0] != 2'b00) || (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFF);
  assign id_exc   = id_exc_q;
`else
  assign addr_bad = 1'b0;
`endif

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q == S_FETCH) && !addr_bad;
  assign fetch_done     = (state_q == S_FETCH) && (addr_bad || imem.imem_ack);
  assign fetch_instr    = addr_bad ? 32'h0000_0000 : imem.imem_rdata;

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_pc8   = id_pc8_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc8_d     = id_pc8_q;
`ifdef IFU_ADEL_EXC_EN
    buf_exc_d    = buf_exc_q;
    id_exc_d     = id_exc_q;
`endif

    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_done) begin
          // Delay slot: the finishing fetch always issues; a redirect only steers the next address.
          if (redirect)          pc_d = redirect_pc;
          else if (pend_valid_q) pc_d = pend_pc_q;
          else                   pc_d = pc_q + STEP;
          pend_valid_d = 1'b0;
          if (stall) begin
            buf_valid_d = 1'b1;
            buf_instr_d = fetch_instr;
            buf_pc_d    = pc_q;
`ifdef IFU_ADEL_EXC_EN
            buf_exc_d   = addr_bad ? 5'd4 : 5'd0;
`endif
            state_d     = S_HOLD;
          end else begin
            id_valid_d = 1'b1;
            id_instr_d = fetch_instr;
            id_pc_d    = pc_q;
            id_pc8_d   = pc_q + 32'd8;
`ifdef IFU_ADEL_EXC_EN
            id_exc_d   = addr_bad ? 5'd4 : 5'd0;
`endif
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall && buf_valid_q) begin
          id_valid_d  = 1'b1;
          id_instr_d  = buf_instr_q;
          id_pc_d     = buf_pc_q;
          id_pc8_d    = buf_pc_q + 32'd8;
`ifdef IFU_ADEL_EXC_EN
          id_exc_d    = buf_exc_q;
`endif
          buf_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (redirect && !fetch_done) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= RESET_PC;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= 32'h0000_0000;
      buf_pc_q     <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0000_0000;
      id_pc_q      <= RESET_PC;
      id_pc8_q     <= RESET_PC + 32'd8;
`ifdef IFU_ADEL_EXC_EN
      buf_exc_q    <= 5'd0;
      id_exc_q     <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc8_q     <= id_pc8_d;
`ifdef IFU_ADEL_EXC_EN
      buf_exc_q    <= buf_exc_d;
      id_exc_q     <= id_exc_d;
`endif
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the pipelined MIPS core.
- Consumes the next-PC decision produced by the next-PC logic (redirect pulse plus target) and owns the PC register.
- Drives a req/ack instruction-memory port and the IF/ID pipeline register.
- Implements the branch delay slot: the fetch in flight when a redirect arrives always completes and issues normally.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- redirect  in  1  one-cycle pulse: taken branch/jump/jr resolved in ID.
- redirect_pc  in  32  target for redirect (same cycle as pulse).
- stall  in  1  hazard-unit stall; IF/ID must hold.
- imem_req  out  1  fetch request, level, held until ack.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  response valid, sampled on rising edge while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID instruction address.
- id_pc8  out  32  id_pc+8, link value for jal/jalr.

Behaviour:
- Reset (async, reset_n=0):
  - state=S_BOOT, pc=RESET_PC, pend_valid=0, buf_valid=0.
  - id_valid=0, id_instr=0, id_pc=RESET_PC, id_pc8=RESET_PC+8.
  - imem_req=0, imem_addr=RESET_PC.
  - Reset mid-request abandons the request; a late ack is ignored because imem_req=0.
- imem_addr=pc at all times; imem_req=1 only in S_FETCH.
- Next fetch address on completion: pend_valid ? pend_pc : pc+PC_STEP, 32-bit wrap, no overflow detection.
- Redirect latch:
  - redirect=1 loads pend_valid=1 and pend_pc=redirect_pc.
  - A later redirect before consumption overwrites the pending target.
  - pend_valid clears when its target is loaded into pc.
  - If redirect coincides with a completing fetch, redirect_pc is used directly as the next pc and pend_valid stays 0.
- S_BOOT: one cycle, then S_FETCH.
- S_FETCH, per edge:
  - ack & !stall: IF/ID <= {1, imem_rdata, pc, pc+8}; pc advances; stay in S_FETCH (back-to-back; one instruction per cycle with a zero-wait memory).
  - ack & stall: buf <= {imem_rdata, pc}, buf_valid=1; pc advances; go S_HOLD. IF/ID holds.
  - !ack & stall: IF/ID holds.
  - !ack & !stall: id_valid<=0 (bubble); id_instr/id_pc retain value.
- S_HOLD:
  - imem_req=0.
  - While stall: everything holds; redirects still latch into pend.
  - On !stall: IF/ID <= buf, buf_valid=0, go S_FETCH. No new fetch is issued in the same cycle.
- Delay slot: a redirect during a stalled or in-flight fetch never kills that fetch; only the address after it changes.
- id_pc8 is always id_pc+8, registered with id_pc.

Optional Feature:
- Macro IFU_ADEL_EXC_EN.
- When defined:
  - Extra output id_exc [4:0].
  - A fetch address with pc[1:0]!=0, or outside 32'h0000_3000..32'h0000_6FFF, is not requested on imem (imem_req=0).
  - The IFU completes that fetch internally in one cycle with instr=32'h0000_0000 and exc code 5'd4 (AdEL), following the same stall/hold rules.
  - id_exc=0 for normal fetches; reset value 0.
- When undefined: no port, no range check, every address is requested.

Test Plan:
- Reset release, zero-wait ack every cycle, no stall -> imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; id_pc follows one cycle later with id_valid=1; id_pc8=0x3008 when id_pc=0x3000.
- redirect=1, redirect_pc=0x3100 while fetch of 0x3008 awaits ack (ack 2 cycles later) -> 0x3008 still reaches ID (delay slot); next imem_addr=0x3100.
- ack arrives with stall=1 for 3 cycles -> IF/ID unchanged, imem_req=0 during hold; on stall release, buffered word appears in ID next edge, new fetch starts the following cycle.
- Two redirects (0x3200 then 0x3400) while one fetch is pending -> next fetch is 0x3400.
- reset_n asserted while imem_req=1, ack then pulsed -> ack ignored; after release, first fetch is 0x3000, id_valid=0 until it completes.
- (IFU_ADEL_EXC_EN) redirect_pc=0x3002 -> no imem_req for it; ID gets id_instr=0, id_pc=0x3002, id_exc=4.
